pacman_dl_ctrl: RTL and testbench
=================================

Name: pacman_dl_ctrl

Overview:
Sequences ROM download from the HPS ioctl stream into the Pacman core's ROM/PROM regions. Decodes the linear download address into per-region write strobes, and holds the core in reset for the whole download plus a stretch period. Reports completion and short or overlong images. Sits between hps_io and the pacman core, and replaces the direct ioctl-to-dn_* wiring and the ad-hoc reset OR.

Parameters:
CPU_END, 16'h4000, first address past CPU program ROM (region 0: 0x0000..CPU_END-1)
GFX_END, 16'h6000, end of gfx ROM (region 1)
PAL_END, 16'h6020, end of colour PROM, 32 B (region 2)
LUT_END, 16'h6120, end of lookup PROM, 256 B (region 3)
SND_END, 16'h6220, end of sound PROM, 256 B (region 4); also the expected image size
RST_HOLD, 16, clk_sys cycles core reset stays asserted after download ends

Ports:
clk_sys  in  1  system clock
RESET  in  1  asynchronous active-high reset
ioctl_download  in  1  download window active
ioctl_wr  in  1  one-cycle byte strobe
ioctl_addr  in  25  byte address within image
ioctl_dout  in  8  byte data
ext_reset  in  1  OSD/button reset request, OR'd into core reset
dn_addr  out  16  region-local address (addr minus region base)
dn_data  out  8  registered byte
dn_we  out  5  one-hot region write strobe, bit n = region n
core_reset  out  1  reset to pacman core
dl_done  out  1  set after a full-length download completes
dl_err  out  1  last download was short (<SND_END bytes) or had a write at or above SND_END

Behaviour:
- Reset values: state IDLE, dn_we=0, dn_addr=0, dn_data=0, core_reset=1, dl_done=0, dl_err=0, byte counter=0, hold counter=0.
- States: IDLE, LOAD, HOLD, RUN.
- IDLE: core_reset=1. Moves to HOLD next cycle, so power-up always gets a RST_HOLD stretch. If ioctl_download=1, moves to LOAD instead.
- LOAD: entered on the ioctl_download rising edge. Clears dl_done, dl_err and the byte counter on entry. core_reset=1.
  - Each ioctl_wr with addr < SND_END: decode region using addr[15:0] and addr[24:16]==0. Register dn_data and dn_addr=addr-base, and pulse the matching dn_we bit for exactly one cycle, one cycle after ioctl_wr (latency 1).
  - Byte counter increments on every ioctl_wr; it saturates at 16'hFFFF.
  - Addr >= SND_END, or addr[24:16]!=0: no strobe, and dl_err is set.
  - Back-to-back ioctl_wr on consecutive cycles must each produce a strobe; no drop.
- LOAD exit: ioctl_download falling edge moves to HOLD. On exit, dl_err |= (byte counter != SND_END). The exit-cycle computation must include any ioctl_wr in that same cycle.
- HOLD: core_reset=1. Hold counter loads RST_HOLD-1 and decrements each cycle; at 0 moves to RUN. dl_done=1 entering RUN if the last LOAD had dl_err=0.
- RUN: core_reset=ext_reset. A new ioctl_download rising edge goes back to LOAD and clears dl_done.
- ext_reset in any state forces core_reset=1 combinationally from the registered state. It does not alter the FSM.
- ioctl_download rising while in HOLD: abort the hold and enter LOAD.
- RESET mid-download: everything returns to reset values immediately. Remaining writes in that window are ignored until the next rising edge of ioctl_download. IDLE→HOLD is blocked while ioctl_download=1 but no rising edge has been seen.

Optional Feature:
DL_CHECKSUM_EN
- Defined: adds output dl_sum[15:0], the modulo-2^16 sum of all accepted bytes (region strobes only) in the last LOAD. It is cleared on LOAD entry and updated in the same cycle as dn_we.
- Not defined: no port, no adder; behaviour otherwise identical.

Test Plan:
- Power-up: RESET pulse, download idle -> core_reset=1 for RST_HOLD+1 cycles after RESET release, then 0; dl_done=0, dl_err=0.
- Full load of 0x6220 bytes, data=addr[7:0], one write every 4 cycles -> dn_we=00001 for 0x0000..0x3FFF; byte at 0x5FFF on dn_we[1], dn_addr=0x1FFF; 0x6020 on dn_we[3], dn_addr=0; 0x6120 on dn_we[4], dn_addr=0; end state dl_done=1, dl_err=0, core_reset released RST_HOLD cycles after download falls.
- Back-to-back writes on 3 consecutive cycles, addr 0x3FFE,0x3FFF,0x4000 -> strobes 00001,00001,00010 on the 3 following cycles, dn_addr 0x3FFE,0x3FFF,0x0000.
- Short image of 0x4000 bytes -> dl_err=1, dl_done=0, core still released after hold.
- Write at 0x6220 and 0x10000 -> no dn_we pulse; dl_err=1.
- New download during HOLD, and RESET asserted mid-LOAD -> respectively re-enter LOAD with core_reset held; all outputs at reset values and no strobes until the next download edge. With DL_CHECKSUM_EN, a full load of bytes 0x01 gives dl_sum=0x6220.

Source files
------------

// File: rtl/pacman_dl_ctrl.sv
// pacman_dl_ctrl: sequences the HPS ioctl ROM download into the Pacman core's
// ROM/PROM regions and keeps the core in reset during download plus a stretch.
// Optional feature macro: DL_CHECKSUM_EN adds dl_sum, the 16-bit sum of all
// bytes accepted into a region during the last download.
module pacman_dl_ctrl #(
  parameter logic [15:0] CPU_END  = 16'h4000,
  parameter logic [15:0] GFX_END  = 16'h6000,
  parameter logic [15:0] PAL_END  = 16'h6020,
  parameter logic [15:0] LUT_END  = 16'h6120,
  parameter logic [15:0] SND_END  = 16'h6220,
  parameter int unsigned RST_HOLD = 16
) (
  input  logic        clk_sys,
  input  logic        RESET,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        ext_reset,
  output logic [15:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic [4:0]  dn_we,
  output logic        core_reset,
  output logic        dl_done,
  output logic        dl_err
`ifdef DL_CHECKSUM_EN
  ,
  output logic [15:0] dl_sum
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HOLD,
    ST_RUN
  } state_t;

  state_t      state_q, state_d;
  logic        dl_prev_q, dl_prev_d;
  logic        loaded_q, loaded_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] hold_q, hold_d;
  logic [15:0] dn_addr_q, dn_addr_d;
  logic [7:0]  dn_data_q, dn_data_d;
  logic [4:0]  dn_we_q, dn_we_d;
  logic        dl_done_q, dl_done_d;
  logic        dl_err_q, dl_err_d;
`ifdef DL_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;
`endif

  logic        dl_rise;
  logic        wr_valid;
  logic [15:0] wr_lo;
  logic [15:0] wr_base;
  logic [4:0]  wr_region;

  // Address decode: region one-hot and base for the current ioctl address.
  always_comb begin
    wr_lo     = ioctl_addr[15:0];
    wr_valid  = (ioctl_addr[24:16] == '0) && (wr_lo < SND_END);
    wr_region = 5'b10000;
    wr_base   = LUT_END;
    if (wr_lo < CPU_END) begin
      wr_region = 5'b00001;
      wr_base   = '0;
    end else if (wr_lo < GFX_END) begin
      wr_region = 5'b00010;
      wr_base   = CPU_END;
    end else if (wr_lo < PAL_END) begin
      wr_region = 5'b00100;
      wr_base   = GFX_END;
    end else if (wr_lo < LUT_END) begin
      wr_region = 5'b01000;
      wr_base   = PAL_END;
    end
  end

  // Next-state, download datapath and status flag logic.
  always_comb begin
    dl_rise   = ioctl_download & ~dl_prev_q;
    state_d   = state_q;
    dl_prev_d = ioctl_download;
    loaded_d  = loaded_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    dn_addr_d = dn_addr_q;
    dn_data_d = dn_data_q;
    dn_we_d   = '0;
    dl_done_d = dl_done_q;
    dl_err_d  = dl_err_q;
`ifdef DL_CHECKSUM_EN
    sum_d     = sum_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // dl_prev resets high, so a download already active at reset
        // release is ignored and parks the FSM here until it ends.
        if (dl_rise) begin
          state_d = ST_LOAD;
        end else if (!ioctl_download) begin
          state_d = ST_HOLD;
          hold_d  = 16'(RST_HOLD - 1);
        end
      end
      ST_LOAD: begin
        if (ioctl_wr) begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 16'd1;
          if (wr_valid) begin
            dn_we_d   = wr_region;
            dn_addr_d = wr_lo - wr_base;
            dn_data_d = ioctl_dout;
`ifdef DL_CHECKSUM_EN
            sum_d     = sum_q + {8'h00, ioctl_dout};
`endif
          end else begin
            dl_err_d = 1'b1;
          end
        end
        // Length check uses cnt_d so a write in the exit cycle is counted.
        if (!ioctl_download) begin
          state_d = ST_HOLD;
          hold_d  = 16'(RST_HOLD - 1);
          if (cnt_d != SND_END) begin
            dl_err_d = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (dl_rise) begin
          state_d = ST_LOAD;
        end else if (hold_q == '0) begin
          state_d = ST_RUN;
          if (loaded_q && !dl_err_q) begin
            dl_done_d = 1'b1;
          end
        end else begin
          hold_d = hold_q - 16'd1;
        end
      end
      ST_RUN: begin
        if (dl_rise) begin
          state_d = ST_LOAD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Fresh download: status and counters restart on LOAD entry.
    if (state_d == ST_LOAD && state_q != ST_LOAD) begin
      cnt_d     = '0;
      dl_err_d  = 1'b0;
      dl_done_d = 1'b0;
      loaded_d  = 1'b1;
`ifdef DL_CHECKSUM_EN
      sum_d     = '0;
`endif
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      dl_prev_q <= 1'b1;
      loaded_q  <= 1'b0;
      cnt_q     <= '0;
      hold_q    <= '0;
      dn_addr_q <= '0;
      dn_data_q <= '0;
      dn_we_q   <= '0;
      dl_done_q <= 1'b0;
      dl_err_q  <= 1'b0;
`ifdef DL_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      dl_prev_q <= dl_prev_d;
      loaded_q  <= loaded_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      dn_addr_q <= dn_addr_d;
      dn_data_q <= dn_data_d;
      dn_we_q   <= dn_we_d;
      dl_done_q <= dl_done_d;
      dl_err_q  <= dl_err_d;
`ifdef DL_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  assign dn_addr    = dn_addr_q;
  assign dn_data    = dn_data_q;
  assign dn_we      = dn_we_q;
  assign dl_done    = dl_done_q;
  assign dl_err     = dl_err_q;
  assign core_reset = (state_q != ST_RUN) | ext_reset;
`ifdef DL_CHECKSUM_EN
  assign dl_sum     = sum_q;
`endif

endmodule

// File: tb/tb_pacman_dl_ctrl.sv
// Testbench for pacman_dl_ctrl: randomized download streams checked against a
// region map model; DL_CHECKSUM_EN enables the dl_sum checks.
`timescale 1ns/1ps
module tb_pacman_dl_ctrl;
  localparam int unsigned RST_HOLD = 16;
  localparam int unsigned IMG      = 32'h6220;

  logic        clk_sys = 1'b0;
  logic        RESET;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ext_reset;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic [4:0]  dn_we;
  logic        core_reset;
  logic        dl_done;
  logic        dl_err;
`ifdef DL_CHECKSUM_EN
  logic [15:0] dl_sum;
`endif

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned m_cnt;
  bit          m_err;
  logic [15:0] m_sum;

  pacman_dl_ctrl #(.RST_HOLD(RST_HOLD)) dut (
    .clk_sys        (clk_sys),
    .RESET          (RESET),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ext_reset      (ext_reset),
    .dn_addr        (dn_addr),
    .dn_data        (dn_data),
    .dn_we          (dn_we),
    .core_reset     (core_reset),
    .dl_done        (dl_done),
    .dl_err         (dl_err)
`ifdef DL_CHECKSUM_EN
    ,
    .dl_sum         (dl_sum)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Region map model: image layout as a list of region end addresses.
  function automatic void model_write(input logic [24:0] a, output logic [4:0] we,
                                      output logic [15:0] off);
    int unsigned ends[5] = '{32'h4000, 32'h6000, 32'h6020, 32'h6120, 32'h6220};
    int unsigned base = 0;
    we  = '0;
    off = '0;
    if (a >= IMG) return;
    for (int r = 0; r < 5; r++) begin
      if (a < ends[r]) begin
        we  = 5'(1 << r);
        off = 16'(a - base);
        return;
      end
      base = ends[r];
    end
  endfunction

  task automatic start_download();
    ioctl_download = 1'b1;
    tick();
    m_cnt = 0;
    m_err = 1'b0;
    m_sum = '0;
  endtask

  task automatic end_download_and_hold(output int unsigned held);
    if (ioctl_download) begin
      ioctl_download = 1'b0;
      tick();
    end
    held = 0;
    while (core_reset === 1'b1 && held < 100) begin
      held++;
      tick();
    end
  endtask

  // mode 0: data=addr[7:0], 1: random, 2: constant 0x01
  task automatic stream(input logic [24:0] start, input int unsigned count, input int mode,
                        input int unsigned max_gap, input bit drop_last);
    logic [4:0]  ew;
    logic [15:0] ea;
    logic [7:0]  d;
    logic [24:0] a;
    int unsigned gap;
    for (int unsigned i = 0; i < count; i++) begin
      a = start + 25'(i);
      case (mode)
        0:       d = a[7:0];
        1:       d = 8'($urandom);
        default: d = 8'h01;
      endcase
      model_write(a, ew, ea);
      m_cnt++;
      if (ew == '0) m_err = 1'b1;
      else m_sum = m_sum + {8'h00, d};
      ioctl_wr   = 1'b1;
      ioctl_addr = a;
      ioctl_dout = d;
      if (drop_last && i == count - 1) ioctl_download = 1'b0;
      tick();
      ioctl_wr = 1'b0;
      tests++;
      if (dn_we !== ew || (ew != '0 && (dn_addr !== ea || dn_data !== d))) begin
        fails++;
        $display("FAIL strobe addr=%h: got we=%b a=%h d=%h, expected we=%b a=%h d=%h",
                 a, dn_we, dn_addr, dn_data, ew, ea, d);
      end
      gap = 0;
      if (max_gap != 0 && i != count - 1 && $urandom_range(0, 15) == 0)
        gap = $urandom_range(1, max_gap);
      repeat (gap) begin
        tick();
        tests++;
        if (dn_we !== 5'b0) begin
          fails++;
          $display("FAIL idle_strobe: got we=%b, expected 00000", dn_we);
        end
      end
    end
  endtask

  task automatic test_reset();
    int unsigned held;
    RESET = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; ext_reset = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0;
    tick(); tick();
    tests++;
    if (dn_we !== 5'b0 || dn_addr !== 16'h0 || dn_data !== 8'h0) begin
      fails++;
      $display("FAIL reset_data: got we=%b a=%h d=%h, expected all zero", dn_we, dn_addr, dn_data);
    end
    tests++;
    if (core_reset !== 1'b1 || dl_done !== 1'b0 || dl_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags: got core_reset=%b done=%b err=%b, expected 1 0 0",
               core_reset, dl_done, dl_err);
    end
    RESET = 1'b0;
    held = 0;
    while (core_reset === 1'b1 && held < 100) begin
      held++;
      tick();
    end
    tests++;
    if (held != RST_HOLD + 1) begin
      fails++;
      $display("FAIL powerup_hold: got %0d cycles, expected %0d", held, RST_HOLD + 1);
    end
    tests++;
    if (dl_done !== 1'b0 || dl_err !== 1'b0) begin
      fails++;
      $display("FAIL powerup_flags: got done=%b err=%b, expected 0 0", dl_done, dl_err);
    end
  endtask

  task automatic test_ext_reset();
    ext_reset = 1'b1;
    #1;
    tests++;
    if (core_reset !== 1'b1) begin
      fails++;
      $display("FAIL ext_reset_on: got %b, expected 1", core_reset);
    end
    repeat (3) tick();
    ext_reset = 1'b0;
    #1;
    tests++;
    if (core_reset !== 1'b0) begin
      fails++;
      $display("FAIL ext_reset_off: got %b, expected 0", core_reset);
    end
  endtask

  task automatic test_full_load();
    int unsigned held;
    start_download();
    stream('0, IMG, 0, 3, 1'b1);
    end_download_and_hold(held);
    tests++;
    if (held != RST_HOLD) begin
      fails++;
      $display("FAIL full_hold: got %0d cycles, expected %0d", held, RST_HOLD);
    end
    tests++;
    if (dl_done !== 1'b1 || dl_err !== 1'b0) begin
      fails++;
      $display("FAIL full_flags: got done=%b err=%b, expected 1 0", dl_done, dl_err);
    end
`ifdef DL_CHECKSUM_EN
    tests++;
    if (dl_sum !== m_sum) begin
      fails++;
      $display("FAIL full_sum: got %h, expected %h", dl_sum, m_sum);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [24:0] addrs[3] = '{25'h3FFE, 25'h3FFF, 25'h4000};
    logic [4:0]  wes[3]   = '{5'b00001, 5'b00001, 5'b00010};
    logic [15:0] offs[3]  = '{16'h3FFE, 16'h3FFF, 16'h0000};
    logic [7:0]  d;
    int unsigned held;
    start_download();
    tests++;
    if (dl_done !== 1'b0 || core_reset !== 1'b1) begin
      fails++;
      $display("FAIL reload_entry: got done=%b core_reset=%b, expected 0 1", dl_done, core_reset);
    end
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom);
      ioctl_wr = 1'b1; ioctl_addr = addrs[i]; ioctl_dout = d;
      tick();
      tests++;
      if (dn_we !== wes[i] || dn_addr !== offs[i] || dn_data !== d) begin
        fails++;
        $display("FAIL b2b_%0d: got we=%b a=%h d=%h, expected we=%b a=%h d=%h",
                 i, dn_we, dn_addr, dn_data, wes[i], offs[i], d);
      end
    end
    ioctl_wr = 1'b0;
    tick();
    tests++;
    if (dn_we !== 5'b0) begin
      fails++;
      $display("FAIL b2b_pulse_width: got we=%b, expected 00000", dn_we);
    end
    end_download_and_hold(held);
  endtask

  task automatic test_short_image();
    int unsigned held;
    start_download();
    stream('0, 32'h4000, 1, 0, 1'b0);
    end_download_and_hold(held);
    tests++;
    if (held != RST_HOLD) begin
      fails++;
      $display("FAIL short_hold: got %0d cycles, expected %0d", held, RST_HOLD);
    end
    tests++;
    if (dl_err !== 1'b1 || dl_done !== 1'b0 || core_reset !== 1'b0) begin
      fails++;
      $display("FAIL short_flags: got err=%b done=%b core_reset=%b, expected 1 0 0",
               dl_err, dl_done, core_reset);
    end
  endtask

  task automatic test_bad_addr();
    int unsigned held;
    start_download();
    stream(25'h0100, 4, 1, 0, 1'b0);
    tests++;
    if (dl_err !== 1'b0) begin
      fails++;
      $display("FAIL bad_pre_err: got %b, expected 0", dl_err);
    end
    stream(25'h6220, 1, 1, 0, 1'b0);
    tests++;
    if (dl_err !== 1'b1) begin
      fails++;
      $display("FAIL bad_err_set: got %b, expected 1", dl_err);
    end
    stream(25'h10000, 2, 1, 0, 1'b0);
    stream(25'h1FF_FFFF, 1, 1, 0, 1'b0);
    stream(25'h6100, 2, 1, 0, 1'b0);
    end_download_and_hold(held);
    tests++;
    if (dl_err !== (m_err | (m_cnt != IMG)) || dl_done !== 1'b0) begin
      fails++;
      $display("FAIL bad_flags: got err=%b done=%b, expected 1 0", dl_err, dl_done);
    end
  endtask

  task automatic test_hold_abort();
    int unsigned held;
    bit released;
    start_download();
    stream(25'h0000, 8, 1, 0, 1'b0);
    ioctl_download = 1'b0;
    tick();
    repeat (5) tick();
    tests++;
    if (core_reset !== 1'b1 || dl_err !== 1'b1) begin
      fails++;
      $display("FAIL abort_in_hold: got core_reset=%b err=%b, expected 1 1", core_reset, dl_err);
    end
    start_download();
    tests++;
    if (core_reset !== 1'b1 || dl_err !== 1'b0 || dl_done !== 1'b0) begin
      fails++;
      $display("FAIL abort_entry: got core_reset=%b err=%b done=%b, expected 1 0 0",
               core_reset, dl_err, dl_done);
    end
    stream(25'h6000, 4, 1, 0, 1'b0);
    released = 1'b0;
    repeat (RST_HOLD + 4) begin
      tick();
      if (core_reset !== 1'b1) released = 1'b1;
    end
    tests++;
    if (released) begin
      fails++;
      $display("FAIL abort_core_reset: got released during LOAD, expected held");
    end
    end_download_and_hold(held);
    tests++;
    if (held != RST_HOLD || dl_err !== 1'b1 || dl_done !== 1'b0) begin
      fails++;
      $display("FAIL abort_end: got hold=%0d err=%b done=%b, expected %0d 1 0",
               held, dl_err, dl_done, RST_HOLD);
    end
  endtask

  task automatic test_reset_mid_load();
    int unsigned held;
    bit strobed, released;
    start_download();
    stream(25'h2000, 6, 1, 0, 1'b0);
    RESET = 1'b1;
    #1;
    tests++;
    if (dn_we !== 5'b0 || dn_addr !== 16'h0 || dn_data !== 8'h0 || core_reset !== 1'b1 ||
        dl_done !== 1'b0 || dl_err !== 1'b0) begin
      fails++;
      $display("FAIL midreset_values: got we=%b a=%h d=%h cr=%b done=%b err=%b, expected 0 0 0 1 0 0",
               dn_we, dn_addr, dn_data, core_reset, dl_done, dl_err);
    end
    tick();
    RESET = 1'b0;
    strobed = 1'b0;
    released = 1'b0;
    for (int unsigned i = 0; i < RST_HOLD + 8; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'h2006 + 25'(i); ioctl_dout = 8'($urandom);
      tick();
      if (dn_we !== 5'b0) strobed = 1'b1;
      if (core_reset !== 1'b1) released = 1'b1;
    end
    ioctl_wr = 1'b0;
    tests++;
    if (strobed || released) begin
      fails++;
      $display("FAIL midreset_ignore: got strobe=%b release=%b, expected 0 0", strobed, released);
    end
    end_download_and_hold(held);
    tests++;
    if (held != RST_HOLD || dl_done !== 1'b0 || dl_err !== 1'b0) begin
      fails++;
      $display("FAIL midreset_after: got hold=%0d done=%b err=%b, expected %0d 0 0",
               held, dl_done, dl_err, RST_HOLD);
    end
    start_download();
    stream(25'h6100, 32'h40, 1, 2, 1'b0);
    end_download_and_hold(held);
  endtask

`ifdef DL_CHECKSUM_EN
  task automatic test_checksum_ones();
    int unsigned held;
    start_download();
    stream('0, IMG, 2, 0, 1'b1);
    end_download_and_hold(held);
    tests++;
    if (dl_sum !== 16'h6220 || dl_done !== 1'b1 || dl_err !== 1'b0) begin
      fails++;
      $display("FAIL sum_ones: got sum=%h done=%b err=%b, expected 6220 1 0", dl_sum, dl_done, dl_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_ext_reset();
    test_full_load();
    test_back_to_back();
    test_short_image();
    test_bad_addr();
    test_hold_abort();
    test_reset_mid_load();
`ifdef DL_CHECKSUM_EN
    test_checksum_ones();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
